// File: rtl/rng_sched_if.sv
// Requester-side bus of the RNG scheduler: level requests in, and a one-hot
// grant pulse carrying a fresh random value back.
interface rng_sched_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 10
);
   logic [NREQ-1:0]  req_i;
   logic [NREQ-1:0]  gnt_o;
   logic [WIDTH-1:0] rand_o;
   logic             valid_o;

   // game logic drives requests and consumes grants
   modport master (output req_i, input gnt_o, rand_o, valid_o);
   // the scheduler consumes requests and produces grants
   modport slave  (input req_i, output gnt_o, rand_o, valid_o);
endinterface

// File: rtl/rng_sched.sv
// Scheduler/arbiter for the shared RNG core. Seeds the core, steps it on idle
// frame ticks and hands each value to exactly one requester, round-robin.
module rng_sched #(
   parameter int               NREQ         = 4,
   parameter int               WIDTH        = 10,
   parameter int               STEP_LAT     = 2,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 10'd661
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_i,
   input  logic             reseed_i,
   input  logic [WIDTH-1:0] seed_i,
   rng_sched_if.slave       bus,
   output logic             busy_o,
   output logic             rng_rst_o,
   output logic [WIDTH-1:0] rng_seed_o,
   output logic             rng_step_o,
   input  logic [WIDTH-1:0] rng_val_i
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {SEED, SETTLE, IDLE, GRANT, STEP, WAIT} state_t;

   state_t           state, state_n;
   logic [PW-1:0]    rr_ptr, rr_ptr_n;
   logic [3:0]       cnt, cnt_n;
   logic             pend_reseed, pend_reseed_n;
   logic             pend_frame, pend_frame_n;
   logic [WIDTH-1:0] seed_lat, seed_lat_n;

   logic [NREQ-1:0]  gnt_q, gnt_n;
   logic [WIDTH-1:0] rand_q, rand_n;
   logic             valid_q, valid_n;
   logic             busy_n, rng_rst_n, rng_step_n;
   logic [WIDTH-1:0] rng_seed_n;

   logic             any_req;
   logic [PW-1:0]    winner, idx;

   assign bus.gnt_o   = gnt_q;
   assign bus.rand_o  = rand_q;
   assign bus.valid_o = valid_q;

   // round-robin search: first asserted request at or after rr_ptr
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      idx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(rr_ptr) + i) % NREQ);
         if (!any_req && bus.req_i[idx]) begin
            any_req = 1'b1;
            winner  = idx;
         end
      end
   end

   // next state, pending-event bookkeeping and next registered outputs
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      rr_ptr_n      = rr_ptr;
      pend_reseed_n = pend_reseed;
      pend_frame_n  = pend_frame;
      seed_lat_n    = seed_lat;
      rng_seed_n    = rng_seed_o;

      // events arriving while busy are remembered; frames collapse to one
      if (state != IDLE) begin
         if (frame_i) pend_frame_n = 1'b1;
         if (reseed_i) begin
            pend_reseed_n = 1'b1;
            seed_lat_n    = seed_i;
         end
      end

      case (state)
         SEED: begin
            state_n = SETTLE;
            cnt_n   = '0;
         end
         SETTLE, WAIT: begin
            if (cnt == 4'(STEP_LAT - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         IDLE: begin
            if (reseed_i || pend_reseed) begin
               // a fresh pulse is newer than any latched seed
               state_n       = SEED;
               rng_seed_n    = reseed_i ? seed_i : seed_lat;
               pend_reseed_n = 1'b0;
               pend_frame_n  = 1'b0;
            end else if (any_req) begin
               state_n  = GRANT;
               rr_ptr_n = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            end else if (frame_i || pend_frame) begin
               state_n = STEP;
            end
         end
         GRANT: state_n = STEP;
         STEP: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         default: state_n = SEED;
      endcase

      // any step, grant-driven or frame-driven, satisfies a pending frame
      if (state_n == STEP) pend_frame_n = 1'b0;

      gnt_n = '0;
      if (state_n == GRANT) gnt_n[winner] = 1'b1;
      valid_n    = (state_n == GRANT);
      rand_n     = (state_n == GRANT) ? rng_val_i : rand_q;
      busy_n     = (state_n != IDLE);
      rng_rst_n  = (state_n == SEED);
      rng_step_n = (state_n == STEP);
   end

   // state and registered outputs; reset restarts from a default-seed load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= SEED;
         cnt         <= '0;
         rr_ptr      <= '0;
         pend_reseed <= 1'b0;
         pend_frame  <= 1'b0;
         seed_lat    <= DEFAULT_SEED;
         gnt_q       <= '0;
         rand_q      <= '0;
         valid_q     <= 1'b0;
         busy_o      <= 1'b1;
         rng_rst_o   <= 1'b1;
         rng_seed_o  <= DEFAULT_SEED;
         rng_step_o  <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         rr_ptr      <= rr_ptr_n;
         pend_reseed <= pend_reseed_n;
         pend_frame  <= pend_frame_n;
         seed_lat    <= seed_lat_n;
         gnt_q       <= gnt_n;
         rand_q      <= rand_n;
         valid_q     <= valid_n;
         busy_o      <= busy_n;
         rng_rst_o   <= rng_rst_n;
         rng_seed_o  <= rng_seed_n;
         rng_step_o  <= rng_step_n;
      end
   end
endmodule

// File: doc/rng_sched.md
Name: rng_sched

Overview:
- Scheduler and arbiter for the shared 10-bit RNG core (ports clk/rst/frame/seed_i/rand_o).
- Owns the RNG's reset, seed and frame-step inputs. Loads the seed at power-up or on a reseed request.
- Shares the RNG output round-robin among NREQ game-logic requesters. Every grant returns a fresh value that no other requester has received.
- Also advances the RNG on each idle video-frame tick so the sequence keeps moving between requests.

Parameters:
- NREQ, 4: number of requesters.
- WIDTH, 10: random value width; must match the RNG core.
- STEP_LAT, 2: cycles to wait after a step or seed before rng_val_i is valid (range 1..15).
- DEFAULT_SEED, 10'd661: seed loaded after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- frame_i  in  1  video frame tick, one-cycle pulse.
- reseed_i  in  1  one-cycle pulse; load seed_i into the RNG.
- seed_i  in  WIDTH  seed value, sampled with reseed_i.
- req_i  in  NREQ  level request per requester.
- gnt_o  out  NREQ  one-hot grant, one-cycle pulse.
- rand_o  out  WIDTH  random value delivered with gnt_o.
- valid_o  out  1  high the same cycle as gnt_o.
- busy_o  out  1  high in every state except IDLE.
- rng_rst_o  out  1  active-high reset/seed-load to the RNG core.
- rng_seed_o  out  WIDTH  seed to the RNG core.
- rng_step_o  out  1  frame/step pulse to the RNG core.
- rng_val_i  in  WIDTH  RNG core output.

Behaviour:
- Reset values:
  - state=SEED, gnt_o=0, rand_o=0, valid_o=0, busy_o=1.
  - rng_rst_o=1, rng_seed_o=DEFAULT_SEED, rng_step_o=0.
  - rr_ptr=0, wait counter=0, pend_reseed=0, pend_frame=0.
- All outputs are registered.
- States: SEED, SETTLE, IDLE, GRANT, STEP, WAIT.
- SEED: rng_rst_o=1 for exactly 1 cycle after reset release or after an accepted reseed. Then go to SETTLE.
- SETTLE and WAIT: count STEP_LAT cycles, then go to IDLE.
- IDLE decision priority: pend_reseed/reseed_i, then any req_i, then pend_frame/frame_i, else stay in IDLE.
- Reseed accepted in IDLE:
  - rng_seed_o <= seed_i (or the latched pending seed); go to SEED.
  - pend_reseed and pend_frame are cleared.
- Request in IDLE:
  - Winner = first asserted req_i at or after rr_ptr, wrapping mod NREQ.
  - Next cycle (GRANT): gnt_o[winner]=1, valid_o=1, rand_o=rng_val_i.
  - rr_ptr <= winner+1 mod NREQ.
  - GRANT lasts 1 cycle, then go to STEP.
- Frame tick in IDLE with no request and no reseed: go to STEP; no grant is issued.
- STEP: rng_step_o=1 for 1 cycle, then go to WAIT.
- Timing:
  - Latency from req_i seen in IDLE to gnt_o is 1 cycle.
  - Minimum spacing between grants is STEP_LAT+3 cycles.
  - No two grants ever carry a value without an intervening step or seed.
- Requester handshake:
  - A requester holds req_i until it sees its gnt_o bit, and may drop it the next cycle.
  - req_i still high in the next IDLE counts as a new request.
  - Dropping req_i before the grant withdraws the request with no side effects.
- Pending events:
  - frame_i outside IDLE sets pend_frame. A single flag: multiple frames collapse into one step.
  - A grant-driven STEP also clears pend_frame.
  - reseed_i outside IDLE sets pend_reseed and latches seed_i; a later reseed_i overwrites the latched seed.
- Simultaneous events in IDLE: reseed wins over req_i. The request stays pending and is served after SETTLE.
- Reset asserted mid-operation: asynchronous return to the reset values. Any in-flight grant is lost; no gnt_o pulse is emitted.
- rand_o holds its last value when valid_o=0.

Test Plan:
- Reset release, bench RNG stub outputs 10'd123 after seed load, STEP_LAT=2 -> rng_rst_o high exactly 1 cycle with rng_seed_o=661. busy_o falls 3 cycles after reset release.
- req_i=4'b0001 held in IDLE, rng_val_i=10'd123 -> next cycle gnt_o=0001, valid_o=1, rand_o=123. rng_step_o pulses the following cycle.
- req_i=4'b1111 held for 20 cycles -> grants in order 0001, 0010, 0100, 1000, 0001. Grants spaced exactly 5 cycles apart; each rand_o matches the stub value after one more step.
- frame_i pulsed in IDLE with req_i=0 -> one rng_step_o pulse, no gnt_o. Three frame_i pulses during WAIT -> exactly one extra rng_step_o.
- reseed_i with seed_i=10'd5 coincident with req_i=4'b0010 in IDLE -> SEED state, rng_seed_o=5. gnt_o=0010 only after SETTLE completes.
- rst driven low during the GRANT cycle -> gnt_o, valid_o and rng_step_o return to 0 immediately. rng_rst_o=1; restart from SEED with rng_seed_o=661.
